// File: rtl/vc_crossbar_rr_sd_pkg.sv
// rtl/vc_crossbar_rr_sd_pkg.sv - shared constants, security labels and width helper for the crossbar
// Contents:
//   VC_CROSSBAR_MAX_PORTS  largest supported port count
//   sec_label_e            L/H label encodings
//   sec_domain_e           per-domain values carried on the domain input
//   idx_nbits()            bits needed to index n items (minimum 1)
package vc_crossbar_rr_sd_pkg;

  localparam int VC_CROSSBAR_MAX_PORTS = 8;

  typedef enum logic [1:0] {
    SEC_L = 2'd0,
    SEC_H = 2'd1
  } sec_label_e;

  typedef enum logic [1:0] {
    DOMAIN_0 = 2'd0,
    DOMAIN_1 = 2'd1,
    DOMAIN_2 = 2'd2,
    DOMAIN_3 = 2'd3
  } sec_domain_e;

  // Also the minimum legal p_dest_nbits for a given port count.
  function automatic int idx_nbits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vc_rr_arb_sd.sv
// rtl/vc_rr_arb_sd.sv - one round-robin arbiter with a registered priority pointer
// Ports:
//   clk, reset  clock, asynchronous active-high reset (pointer -> 0)
//   reqs        request vector, one bit per requester
//   en          advance the pointer past the current winner at the next edge
//   grants      one-hot grant (all zero when nothing requests)
module vc_rr_arb_sd
  import vc_crossbar_rr_sd_pkg::*;
#(
  parameter int p_num_reqs = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [p_num_reqs-1:0] reqs,
  input  logic                  en,
  output logic [p_num_reqs-1:0] grants
);

  localparam int PW = idx_nbits(p_num_reqs);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_next;
  logic [PW:0]   sum;
  logic [PW-1:0] idx;
  logic          found;

  // Search starts at ptr and wraps; the one extra sum bit keeps the wrap
  // compare exact for non power-of-two requester counts.
  always_comb begin
    grants   = '0;
    ptr_next = ptr;
    found    = 1'b0;
    sum      = '0;
    idx      = '0;
    for (int k = 0; k < p_num_reqs; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(p_num_reqs)) begin
        sum = sum - (PW+1)'(p_num_reqs);
      end
      idx = sum[PW-1:0];
      if (!found && reqs[idx]) begin
        found       = 1'b1;
        grants[idx] = 1'b1;
        ptr_next    = (idx == PW'(p_num_reqs - 1)) ? '0 : idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= ptr_next;
    end
  end

endmodule

// File: rtl/vc_crossbar_rr_sd.sv
// rtl/vc_crossbar_rr_sd.sv - NxN val/rdy crossbar, per-output round-robin, one-entry output buffers
// Optional feature macro: VC_CROSSBAR_DOMAIN_SCRUB_EN (clear all buffers on a domain change)
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   domain      security domain of every payload this cycle
//   in_val/in_rdy/in_dest/in_msg   per-input handshake, destination, payload (packed by port)
//   out_val/out_rdy/out_msg        per-output handshake and payload (packed by port)
//   bad_dest    one-cycle pulse after an out-of-range destination is consumed
module vc_crossbar_rr_sd
  import vc_crossbar_rr_sd_pkg::*;
#(
  parameter int p_nbits      = 32,
  parameter int p_num_ports  = 3,
  parameter int p_dest_nbits = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [1:0]                        domain,
  input  logic [p_num_ports-1:0]            in_val,
  output logic [p_num_ports-1:0]            in_rdy,
  input  logic [p_num_ports*p_dest_nbits-1:0] in_dest,
  input  logic [p_num_ports*p_nbits-1:0]    in_msg,
  output logic [p_num_ports-1:0]            out_val,
  input  logic [p_num_ports-1:0]            out_rdy,
  output logic [p_num_ports*p_nbits-1:0]    out_msg,
  output logic                              bad_dest
);

  localparam int N  = p_num_ports;
  localparam int DB = p_dest_nbits;
  localparam int W  = p_nbits;

  generate
    if (N < 2 || N > VC_CROSSBAR_MAX_PORTS || DB < idx_nbits(N)) begin : g_bad_cfg
      $error("vc_crossbar_rr_sd: unsupported p_num_ports/p_dest_nbits combination");
    end
  endgenerate

  // scrub: a domain change clears every buffer and blocks all inputs for one cycle.
  logic scrub;
`ifdef VC_CROSSBAR_DOMAIN_SCRUB_EN
  logic [1:0] domain_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      domain_q <= '0;
    end else begin
      domain_q <= domain;
    end
  end

  assign scrub = (domain != domain_q);
`else
  // Without the scrub feature domain only labels the data; it never affects control.
  assign scrub = 1'b0 & (^domain);
`endif

  logic [N-1:0] reqs [N];     // reqs[j][i]: input i wants output j
  logic [N-1:0] raw_gnt [N];
  logic [N-1:0] gnt [N];
  logic [W-1:0] sel_msg [N];
  logic [N-1:0] can_accept;
  logic [N-1:0] arb_en;
  logic [N-1:0] bad;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      bad[i] = in_val[i] && ({1'b0, in_dest[i*DB +: DB]} >= (DB+1)'(N));
    end
    for (int j = 0; j < N; j++) begin
      can_accept[j] = !out_val[j] || out_rdy[j];
      for (int i = 0; i < N; i++) begin
        reqs[j][i] = in_val[i] && (in_dest[i*DB +: DB] == DB'(j));
      end
    end
  end

  genvar gj;
  generate
    for (gj = 0; gj < N; gj++) begin : g_out
      vc_rr_arb_sd #(
        .p_num_reqs (N)
      ) u_arb (
        .clk    (clk),
        .reset  (reset),
        .reqs   (reqs[gj]),
        .en     (arb_en[gj]),
        .grants (raw_gnt[gj])
      );

      // A grant counts only when the buffer can take the word, so en doubles
      // as "transfer happens at the next edge".
      assign arb_en[gj] = can_accept[gj] && (|reqs[gj]) && !scrub;
      assign gnt[gj]    = arb_en[gj] ? raw_gnt[gj] : '0;
    end
  endgenerate

  always_comb begin
    for (int i = 0; i < N; i++) begin
      in_rdy[i] = bad[i] && !scrub;
      for (int j = 0; j < N; j++) begin
        in_rdy[i] = in_rdy[i] | gnt[j][i];
      end
    end
    for (int j = 0; j < N; j++) begin
      sel_msg[j] = '0;
      for (int i = 0; i < N; i++) begin
        if (gnt[j][i]) begin
          sel_msg[j] = sel_msg[j] | in_msg[i*W +: W];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_val  <= '0;
      out_msg  <= '0;
      bad_dest <= 1'b0;
    end else begin
      bad_dest <= (|bad) && !scrub;
      for (int j = 0; j < N; j++) begin
        if (scrub) begin
          out_val[j]        <= 1'b0;
          out_msg[j*W +: W] <= '0;
        end else if (arb_en[j]) begin
          out_val[j]        <= 1'b1;
          out_msg[j*W +: W] <= sel_msg[j];
        end else if (out_rdy[j]) begin
          out_val[j]        <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vc_crossbar_rr_sd.sv
// tb/tb_vc_crossbar_rr_sd.sv - scoreboard bench for vc_crossbar_rr_sd (3 ports, 32-bit payload)
module tb_vc_crossbar_rr_sd;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  domain;
  logic [2:0]  in_val;
  logic [2:0]  in_rdy;
  logic [5:0]  in_dest;
  logic [95:0] in_msg;
  logic [2:0]  out_val;
  logic [2:0]  out_rdy;
  logic [95:0] out_msg;
  logic        bad_dest;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q [3][$];
  logic [31:0] mon_exp;

  vc_crossbar_rr_sd #(
    .p_nbits      (32),
    .p_num_ports  (3),
    .p_dest_nbits (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .domain   (domain),
    .in_val   (in_val),
    .in_rdy   (in_rdy),
    .in_dest  (in_dest),
    .in_msg   (in_msg),
    .out_val  (out_val),
    .out_rdy  (out_rdy),
    .out_msg  (out_msg),
    .bad_dest (bad_dest)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic v, input logic [1:0] d, input logic [31:0] m);
    in_val[i]        = v;
    in_dest[i*2 +: 2] = d;
    in_msg[i*32 +: 32] = m;
  endtask

  // Monitor: every word accepted by a sink must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      for (int j = 0; j < 3; j++) begin
        if (out_val[j] && out_rdy[j]) begin
          if (exp_q[j].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_out%0d: got %0h expected no message", j, out_msg[j*32 +: 32]);
          end else begin
            mon_exp = exp_q[j].pop_front();
            check($sformatf("sb_out%0d", j), {64'd0, out_msg[j*32 +: 32]}, {64'd0, mon_exp});
          end
        end
      end
    end
  end

`ifndef VC_CROSSBAR_DOMAIN_SCRUB_EN
  logic [1:0] dom_prev = 2'd0;
  always @(posedge clk) begin
    if (!reset && domain !== dom_prev && |out_val) begin
      checks++;
      errors++;
      $display("FAIL domain_protocol: got domain change with out_val %b expected 000", out_val);
    end
    dom_prev = domain;
  end
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rr_exp [4];
    rr_exp = '{3'b001, 3'b010, 3'b100, 3'b001};

    in_val  = '0;
    in_dest = '0;
    in_msg  = '0;
    out_rdy = 3'b111;
    domain  = 2'd0;

    #1 reset = 1'b1;
    #1;
    check("rst_out_val", {93'd0, out_val}, 96'd0);
    check("rst_out_msg", out_msg, 96'd0);
    check("rst_bad_dest", {95'd0, bad_dest}, 96'd0);
    step();
    step();
    reset = 1'b0;

    // Contention on output 1: grants rotate 0,1,2,0.
    set_in(0, 1'b1, 2'd1, 32'hA0);
    set_in(1, 1'b1, 2'd1, 32'hA1);
    set_in(2, 1'b1, 2'd1, 32'hA2);
    exp_q[1].push_back(32'hA0);
    exp_q[1].push_back(32'hA1);
    exp_q[1].push_back(32'hA2);
    exp_q[1].push_back(32'hA0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("rr_in_rdy%0d", k), {93'd0, in_rdy}, {93'd0, rr_exp[k]});
      step();
    end
    in_val = '0;
    step();

    // Permutation: 0->1, 1->2, 2->0 all in one cycle.
    set_in(0, 1'b1, 2'd1, 32'h10);
    set_in(1, 1'b1, 2'd2, 32'h11);
    set_in(2, 1'b1, 2'd0, 32'h12);
    exp_q[1].push_back(32'h10);
    exp_q[2].push_back(32'h11);
    exp_q[0].push_back(32'h12);
    #1;
    check("perm_in_rdy", {93'd0, in_rdy}, {93'd0, 3'b111});
    step();
    in_val = '0;
    check("perm_out_val", {93'd0, out_val}, {93'd0, 3'b111});
    step();

    // Backpressure on output 0, then drain and refill in one cycle.
    out_rdy = 3'b000;
    set_in(0, 1'b1, 2'd0, 32'hB0);
    exp_q[0].push_back(32'hB0);
    #1;
    check("bp_first_in_rdy", {93'd0, in_rdy}, {93'd0, 3'b001});
    step();
    in_val = '0;
    set_in(2, 1'b1, 2'd0, 32'hB2);
    #1;
    check("bp_stall_in_rdy", {93'd0, in_rdy}, 96'd0);
    step();
    check("bp_hold_val", {95'd0, out_val[0]}, 96'd1);
    check("bp_hold_msg", {64'd0, out_msg[31:0]}, {64'd0, 32'hB0});
    out_rdy = 3'b001;
    exp_q[0].push_back(32'hB2);
    #1;
    check("bp_refill_in_rdy", {93'd0, in_rdy}, {93'd0, 3'b100});
    step();
    in_val = '0;
    check("bp_refill_val", {95'd0, out_val[0]}, 96'd1);
    step();
    out_rdy = 3'b111;
    step();

    // Bad destination on input 1.
    set_in(1, 1'b1, 2'd3, 32'h55);
    #1;
    check("bad_in_rdy", {93'd0, in_rdy}, {93'd0, 3'b010});
    step();
    in_val = '0;
    check("bad_pulse", {95'd0, bad_dest}, 96'd1);
    check("bad_no_out", {93'd0, out_val}, 96'd0);
    step();
    check("bad_pulse_end", {95'd0, bad_dest}, 96'd0);

    // Reset mid-stream with all buffers full; pointer of output 2 left at 2.
    out_rdy = 3'b000;
    set_in(0, 1'b1, 2'd1, 32'hC0);
    set_in(1, 1'b1, 2'd2, 32'hC1);
    set_in(2, 1'b1, 2'd0, 32'hC2);
    step();
    in_val = '0;
    check("mid_full", {93'd0, out_val}, {93'd0, 3'b111});
    #1 reset = 1'b1;
    #1;
    check("mid_rst_val", {93'd0, out_val}, 96'd0);
    check("mid_rst_msg", out_msg, 96'd0);
    #1 reset = 1'b0;
    out_rdy = 3'b111;
    set_in(0, 1'b1, 2'd2, 32'hD0);
    set_in(1, 1'b1, 2'd2, 32'hD1);
    set_in(2, 1'b1, 2'd2, 32'hD2);
    exp_q[2].push_back(32'hD0);
    #1;
    check("mid_first_grant", {93'd0, in_rdy}, {93'd0, 3'b001});
    step();
    in_val = '0;
    step();

`ifdef VC_CROSSBAR_DOMAIN_SCRUB_EN
    // Domain change while output 2 holds 0xDEAD.
    out_rdy = 3'b011;
    set_in(0, 1'b1, 2'd2, 32'hDEAD);
    step();
    in_val = '0;
    check("scrub_pre_val", {95'd0, out_val[2]}, 96'd1);
    check("scrub_pre_msg", {64'd0, out_msg[95:64]}, {64'd0, 32'hDEAD});
    domain = 2'd1;
    set_in(0, 1'b1, 2'd0, 32'h77);
    #1;
    check("scrub_in_rdy", {93'd0, in_rdy}, 96'd0);
    step();
    in_val = '0;
    check("scrub_out_val", {93'd0, out_val}, 96'd0);
    check("scrub_out_msg", {64'd0, out_msg[95:64]}, 96'd0);
    out_rdy = 3'b111;
    step();
`endif

    step();
    step();
    for (int j = 0; j < 3; j++) begin
      check($sformatf("sb_drain%0d", j), 96'(exp_q[j].size()), 96'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
